// File: rtl/fetch_redirect.sv
// Instruction-fetch PC unit: issues word fetches, fills the IF/ID register and applies branch/JAL redirects.
// Optional redirect statistics counter enabled by defining FETCH_REDIRECT_STATS_EN.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        br_success,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        take_redirect;
  logic        fetch_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'd0;
      if_pc_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Branch inputs only steer next-state logic; outputs are all registered or decoded from state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    take_redirect = 1'b0;
    fetch_step    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        if_valid_d = 1'b0;
        if_instr_d = 32'd0;
      end
      FETCH: begin
        if (br_success) begin
          take_redirect = 1'b1;
          state_d       = REDIRECT;
          pc_d          = br_pc + br_offset;
          if_valid_d    = 1'b0;
          if_instr_d    = 32'd0;
        end else if (!stall_in) begin
          fetch_step = 1'b1;
        end
      end
      REDIRECT: begin
        // Branch and stall here come from squashed instructions, so they are ignored.
        state_d    = FETCH;
        fetch_step = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (fetch_step) begin
      if (imem_ready) begin
        if_instr_d = imem_rdata;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + 32'd1;
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = 32'd0;
      end
    end
  end

  assign imem_req  = (state_q != BOOT);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign flush     = (state_q == REDIRECT);

`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] redirect_count_q, redirect_count_d;

  always_comb begin
    redirect_count_d = redirect_count_q;
    if (take_redirect && (redirect_count_q != 32'hFFFF_FFFF)) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_count_q <= 32'd0;
    end else begin
      redirect_count_q <= redirect_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Scoreboard bench for fetch_redirect: directed per-cycle vectors queued by the stimulus,
// checked by an independent negedge monitor.
module tb_fetch_redirect;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        br_success;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [31:0] redirect_count;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_redirect dut (
    .clk        (clk),
    .reset      (reset),
    .stall_in   (stall_in),
    .br_success (br_success),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .flush      (flush)
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    .redirect_count (redirect_count)
`endif
  );

`ifndef FETCH_REDIRECT_STATS_EN
  assign redirect_count = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory content is a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_2468;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      chk("imem_addr", imem_addr, e.addr);
      chk("if_valid", {31'd0, if_valid}, {31'd0, e.valid});
      chk("flush", {31'd0, flush}, {31'd0, e.flush});
      if (e.valid) begin
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, mem_word(e.pc));
      end
`ifdef FETCH_REDIRECT_STATS_EN
      chk("redirect_count", redirect_count, e.cnt);
`endif
      $display("cycle t=%0t addr=%08h req=%0b valid=%0b pc=%08h flush=%0b",
               $time, imem_addr, imem_req, if_valid, if_pc, flush);
    end
  end

  // Drive one cycle of inputs, then queue the expected post-edge outputs.
  task automatic step(input logic st, input logic br, input logic rdy,
                      input logic [31:0] bpc, input logic [31:0] boff,
                      input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_pc, input logic e_flush, input logic [31:0] e_cnt);
    exp_t e;
    stall_in   = st;
    br_success = br;
    imem_ready = rdy;
    br_pc      = bpc;
    br_offset  = boff;
    @(posedge clk);
    e.req   = e_req;
    e.addr  = e_addr;
    e.valid = e_valid;
    e.pc    = e_pc;
    e.flush = e_flush;
    e.cnt   = e_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd1);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
    chk("rst_redirect_count", redirect_count, 32'd0);
`endif
  endtask

  initial begin
    reset      = 1'b0;
    stall_in   = 1'b0;
    br_success = 1'b0;
    br_pc      = 32'd0;
    br_offset  = 32'd0;
    imem_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check_reset_state();
    chk("rst_if_pc", if_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Boot, then sequential fetch with if_pc trailing imem_addr.
    step(0, 0, 1, 0, 0, 1, 32'd1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd2, 1, 32'd1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd3, 1, 32'd2, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd4, 1, 32'd3, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd5, 1, 32'd4, 0, 0);
    // Three stall cycles at PC=5 discard the ready word.
    step(1, 0, 1, 0, 0, 1, 32'd5, 1, 32'd4, 0, 0);
    step(1, 0, 1, 0, 0, 1, 32'd5, 1, 32'd4, 0, 0);
    step(1, 0, 1, 0, 0, 1, 32'd5, 1, 32'd4, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd6, 1, 32'd5, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd7, 1, 32'd6, 0, 0);
    // Backward branch 8 + (-4); second pulse (with stall) inside REDIRECT is ignored.
    step(0, 1, 1, 32'd8, 32'hFFFF_FFFC, 1, 32'd4, 0, 0, 1, 1);
    step(1, 1, 1, 32'd100, 32'd0, 1, 32'd5, 1, 32'd4, 0, 1);
    step(0, 0, 1, 0, 0, 1, 32'd6, 1, 32'd5, 0, 1);
    // Redirect beats a concurrent stall; then a memory-wait bubble inside REDIRECT.
    step(1, 1, 1, 32'd20, 32'd3, 1, 32'd23, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 32'd23, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 1, 32'd24, 1, 32'd23, 0, 2);
    // Redirect to 0xFFFFFFFF, wrap to 0, then bubbles with PC held.
    step(0, 1, 1, 32'hFFFF_FFFE, 32'd1, 1, 32'hFFFF_FFFF, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 1, 32'd0, 1, 32'hFFFF_FFFF, 0, 3);
    step(0, 0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 1, 32'd1, 1, 32'd0, 0, 3);
    // Redirect, then assert reset in the middle of the REDIRECT cycle.
    step(0, 1, 1, 32'd0, 32'd40, 1, 32'd40, 0, 0, 1, 4);
    #2 reset = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 1, 0, 0, 1, 32'd1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'd2, 1, 32'd1, 0, 0);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got %0d pending, expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
